// File: rtl/sfp_pkg.sv
// Shared definitions for the special-function processor array: FSM encoding
// and saturation limits. The optional saturating add is enabled by defining
// the SFP_SAT_EN macro.
package sfp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } sfp_state_e;

  // Largest positive signed value of a bw-bit word (bit pattern 0111..1)
  function automatic logic [63:0] psum_max(input int unsigned bw);
    return (64'd1 << (bw - 1)) - 64'd1;
  endfunction

  // Most negative signed value of a bw-bit word (bit pattern 1000..0 after truncation)
  function automatic logic [63:0] psum_min(input int unsigned bw);
    return 64'd1 << (bw - 1);
  endfunction

endpackage

// File: rtl/sfp_lane.sv
// One channel of the special-function processor: signed accumulator,
// wrap-around or saturating add (SFP_SAT_EN), and ReLU output mux.
module sfp_lane
  import sfp_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         acc_en_i,
  input  logic         relu_en_i,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] out_o
);

  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] sum;
  logic [W-1:0] sum_sat;

  // Raw two's-complement sum of the accumulator and the incoming psum
  always_comb sum = acc_q + in_i;

`ifdef SFP_SAT_EN
  logic ovf_pos, ovf_neg;

  // Overflow is only possible when both operands share a sign the result lacks
  always_comb begin
    ovf_pos = ~acc_q[W-1] & ~in_i[W-1] &  sum[W-1];
    ovf_neg =  acc_q[W-1] &  in_i[W-1] & ~sum[W-1];
    sum_sat = sum;
    if (ovf_pos) begin
      sum_sat = W'(psum_max(W));
    end else if (ovf_neg) begin
      sum_sat = W'(psum_min(W));
    end
  end
`else
  // Plain wrap-around accumulation
  always_comb sum_sat = sum;
`endif

  // Accumulator next value: clear on start, add on an accepted beat, else hold
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = sum_sat;
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // ReLU: negative sums clamp to zero when enabled
  always_comb out_o = (relu_en_i && acc_q[W-1]) ? '0 : acc_q;

endmodule

// File: rtl/sfp_array.sv
// Multi-channel special-function processor: accumulates acc_len signed psum
// beats per channel, then presents the (optionally ReLU'd) sums for one cycle.
// Define SFP_SAT_EN to make each channel add saturate instead of wrap.
module sfp_array
  import sfp_pkg::*;
#(
  parameter int unsigned psum_bw = 16,
  parameter int unsigned col     = 8,
  parameter int unsigned cnt_bw  = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [cnt_bw-1:0]      acc_len,
  input  logic                   relu_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [col*psum_bw-1:0] in,
  output logic [col*psum_bw-1:0] out,
  output logic                   out_valid,
  output logic                   busy
);

  sfp_state_e        state_q, state_d;
  logic [cnt_bw-1:0] cnt_q, cnt_d;
  logic [cnt_bw-1:0] len_q, len_d;
  logic              relu_q, relu_d;
  logic              clr_c;
  logic              accept_c;

  // Next-state, counter and latch logic; start overrides everything in any state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    relu_d   = relu_q;
    clr_c    = 1'b0;
    accept_c = 1'b0;
    if (start) begin
      clr_c   = 1'b1;
      cnt_d   = '0;
      len_d   = acc_len;
      relu_d  = relu_en;
      state_d = (acc_len == '0) ? ST_OUT : ST_ACC;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            accept_c = 1'b1;
            cnt_d    = cnt_q + cnt_bw'(1);
            if (cnt_d == len_q) begin
              state_d = ST_OUT;
            end
          end
        end
        ST_OUT:  state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      relu_q  <= relu_d;
    end
  end

  // Handshake and status decoded straight from the state register
  always_comb begin
    in_ready  = (state_q == ST_ACC);
    out_valid = (state_q == ST_OUT);
    busy      = (state_q != ST_IDLE);
  end

  // One lane per channel, all sharing the control above
  for (genvar g = 0; g < int'(col); g++) begin : g_lane
    sfp_lane #(
      .W(psum_bw)
    ) u_lane (
      .clk      (clk),
      .rst_n    (reset),
      .clr_i    (clr_c),
      .acc_en_i (accept_c),
      .relu_en_i(relu_q),
      .in_i     (in[g*psum_bw +: psum_bw]),
      .out_o    (out[g*psum_bw +: psum_bw])
    );
  end

endmodule

// File: tb/tb_sfp_array.sv
// Self-checking bench for sfp_array: vector table plus hand-written corner
// sequences, with expected results queued at start and popped on out_valid.
module tb_sfp_array;

  localparam int PBW = 16;
  localparam int COL = 8;
  localparam int CBW = 5;
  localparam int DW  = PBW * COL;

  logic           clk;
  logic           reset;
  logic           start;
  logic [CBW-1:0] acc_len;
  logic           relu_en;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_bus;
  logic [DW-1:0]  out_bus;
  logic           out_valid;
  logic           busy;

  sfp_array #(.psum_bw(PBW), .col(COL), .cnt_bw(CBW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .acc_len  (acc_len),
    .relu_en  (relu_en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (in_bus),
    .out      (out_bus),
    .out_valid(out_valid),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]       len;
    logic             relu;
    logic [3:0][15:0] b0;
    logic [3:0][15:0] b1;
    logic [3:0]       gap;
    logic [15:0]      e0;
    logic [15:0]      e1;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sb_q[$];
  vec_t          vecs[7];

  function automatic vec_t mk(int len, bit relu, int a0, int a1, int a2, int a3,
                              int c0, int c1, int c2, int c3, int gap, int e0, int e1);
    vec_t v;
    v.len  = 5'(len);
    v.relu = relu;
    v.b0[0] = 16'(a0); v.b0[1] = 16'(a1); v.b0[2] = 16'(a2); v.b0[3] = 16'(a3);
    v.b1[0] = 16'(c0); v.b1[1] = 16'(c1); v.b1[2] = 16'(c2); v.b1[3] = 16'(c3);
    v.gap  = 4'(gap);
    v.e0   = 16'(e0);
    v.e1   = 16'(e1);
    return v;
  endfunction

  // Reference channel add: clamp or wrap depending on the build
  function automatic int model_add(int a, int b);
    int s;
    logic signed [15:0] t;
    s = a + b;
`ifdef SFP_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    t = 16'(s);
`else
    t = 16'(s);
`endif
    return int'(t);
  endfunction

  function automatic int beat_val(vec_t v, int c, int i);
    logic signed [15:0] t;
    if (c == 0) begin
      t = v.b0[i];
      return int'(t);
    end else if (c == 1) begin
      t = v.b1[i];
      return int'(t);
    end
    return (c * 37 - 150) * (i + 1);
  endfunction

  // Expected output: channels 0/1 from the table, the rest from the model
  function automatic logic [DW-1:0] expect_vec(vec_t v);
    logic [DW-1:0] e;
    int acc;
    e = '0;
    for (int c = 2; c < COL; c++) begin
      acc = 0;
      for (int i = 0; i < int'(v.len); i++) acc = model_add(acc, beat_val(v, c, i));
      if (v.relu && acc < 0) acc = 0;
      e[c*PBW +: PBW] = 16'(acc);
    end
    e[0 +: PBW]   = v.e0;
    e[PBW +: PBW] = v.e1;
    return e;
  endfunction

  function automatic logic [DW-1:0] rep(int val);
    logic [DW-1:0] r;
    for (int c = 0; c < COL; c++) r[c*PBW +: PBW] = 16'(val);
    return r;
  endfunction

  task automatic chk_bus(string name, logic [DW-1:0] act, logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, expv);
    end
  endtask

  task automatic chk1(string name, logic act, logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, act, expv);
    end
  endtask

  // Advance one clock, sample after the edge, score any out_valid pulse
  task automatic tick();
    logic [DW-1:0] e;
    @(posedge clk);
    #1;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out_valid got out %h expected no pulse", out_bus);
      end else begin
        e = sb_q.pop_front();
        chk_bus("out", out_bus, e);
      end
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 8 && sb_q.size() > 0; k++) tick();
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic run_vec(vec_t v);
    start    = 1'b1;
    acc_len  = v.len;
    relu_en  = v.relu;
    in_valid = 1'b0;
    sb_q.push_back(expect_vec(v));
    tick();
    start = 1'b0;
    for (int i = 0; i < int'(v.len); i++) begin
      for (int g = 0; g < int'(v.gap); g++) tick();
      for (int c = 0; c < COL; c++) in_bus[c*PBW +: PBW] = 16'(beat_val(v, c, i));
      in_valid = 1'b1;
      chk1("in_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
    end
    wait_done();
    tick();
    chk1("busy_after_out", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(3, 1, 5, -2, 4, 0, -10, 3, 1, 0, 0, 7, 0);
    vecs[1] = mk(3, 0, 5, -2, 4, 0, -10, 3, 1, 0, 0, 7, -6);
    vecs[2] = mk(3, 0, 5, -2, 4, 0, -10, 3, 1, 0, 2, 7, -6);
    vecs[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef SFP_SAT_EN
    vecs[4] = mk(2, 0, 30000, 10000, 0, 0, 0, 0, 0, 0, 0, 32767, 0);
    vecs[5] = mk(2, 1, 30000, 10000, 0, 0, -30000, -10000, 0, 0, 1, 32767, 0);
`else
    vecs[4] = mk(2, 0, 30000, 10000, 0, 0, 0, 0, 0, 0, 0, -25536, 0);
    vecs[5] = mk(2, 1, 30000, 10000, 0, 0, -30000, -10000, 0, 0, 1, 0, 25536);
`endif
    vecs[6] = mk(4, 0, 1, 1, 1, 1, -1, -1, -1, -1, 1, 4, -4);

    reset    = 1'b0;
    start    = 1'b0;
    acc_len  = '0;
    relu_en  = 1'b0;
    in_valid = 1'b0;
    in_bus   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_bus("reset_out", out_bus, '0);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_in_ready", in_ready, 1'b0);
    reset = 1'b1;
    tick();

    for (int n = 0; n < 7; n++) run_vec(vecs[n]);

    // Abort mid-accumulation: first sum and the start-cycle beat are dropped
    tick();
    start = 1'b1; acc_len = 5'd4; relu_en = 1'b0;
    tick();
    start = 1'b0; in_bus = rep(7); in_valid = 1'b1;
    tick();
    start = 1'b1; in_bus = rep(100); in_valid = 1'b1;
    sb_q.push_back(rep(4));
    tick();
    start = 1'b0; in_bus = rep(1);
    repeat (4) tick();
    in_valid = 1'b0;
    wait_done();
    tick();

    // start together with in_valid in IDLE: beat is not counted
    chk1("idle_busy", busy, 1'b0);
    start = 1'b1; acc_len = 5'd2; relu_en = 1'b0; in_bus = rep(50); in_valid = 1'b1;
    chk1("idle_in_ready", in_ready, 1'b0);
    sb_q.push_back(rep(2));
    tick();
    start = 1'b0; in_bus = rep(1);
    repeat (2) tick();
    in_valid = 1'b0;
    wait_done();
    tick();

    // start during OUT: pulse still seen, then straight into a cleared ACC
    start = 1'b1; acc_len = 5'd1; relu_en = 1'b0;
    sb_q.push_back(rep(3));
    tick();
    start = 1'b0; in_bus = rep(3); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    start = 1'b1; acc_len = 5'd1; relu_en = 1'b0;
    sb_q.push_back(rep(9));
    tick();
    start = 1'b0;
    chk1("restart_busy", busy, 1'b1);
    chk1("restart_in_ready", in_ready, 1'b1);
    chk1("restart_no_pulse", out_valid, 1'b0);
    in_bus = rep(9); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done();
    tick();

    // Asynchronous reset mid-accumulation
    start = 1'b1; acc_len = 5'd3; relu_en = 1'b0;
    tick();
    start = 1'b0; in_bus = rep(5); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_bus("async_rst_out", out_bus, '0);
    chk1("async_rst_out_valid", out_valid, 1'b0);
    chk1("async_rst_busy", busy, 1'b0);
    chk1("async_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) tick();
    run_vec(vecs[1]);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
